// File: rtl/burst_if_pkg.sv
// Shared types and timing constants for the burst memory interface responder.
package burst_if_pkg;

   localparam int LEN_BITS       = 10;
   localparam int WR_CAPTURE_DLY = 1;
   localparam int RD_LAT         = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_TAIL,
      S_WR_FIN,
      S_RD_ISSUE,
      S_RD_DRAIN,
      S_RD_FIN
   } state_t;

endpackage

// File: rtl/burst_ram_sdp.sv
// Simple-dual-port RAM: one write port, one registered read port, no array reset.
module burst_ram_sdp #(
   parameter int DATA_BITS  = 64,
   parameter int DEPTH_BITS = 12
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [DEPTH_BITS-1:0] waddr_i,
   input  logic [DATA_BITS-1:0]  wdata_i,
   input  logic                  re_i,
   input  logic [DEPTH_BITS-1:0] raddr_i,
   output logic [DATA_BITS-1:0]  rdata_o
);

   logic [DATA_BITS-1:0] mem_q [2**DEPTH_BITS];
   logic [DATA_BITS-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Burst-interface responder backed by on-chip RAM; mimics the DDR3 controller
// data_req / data_valid / finish timing so it can stand in for it.
module burst_mem_responder
   import burst_if_pkg::*;
#(
   parameter int MEM_DATA_BITS = 64,
   parameter int ADDR_BITS     = 24,
   parameter int DEPTH_BITS    = 12
) (
   input  logic                     mem_clk,
   input  logic                     rst,
   input  logic                     rd_burst_req,
   input  logic                     wr_burst_req,
   input  logic [LEN_BITS-1:0]      rd_burst_len,
   input  logic [LEN_BITS-1:0]      wr_burst_len,
   input  logic [ADDR_BITS-1:0]     rd_burst_addr,
   input  logic [ADDR_BITS-1:0]     wr_burst_addr,
   output logic                     rd_burst_data_valid,
   output logic [MEM_DATA_BITS-1:0] rd_burst_data,
   output logic                     wr_burst_data_req,
   input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
   output logic                     rd_burst_finish,
   output logic                     wr_burst_finish,
   output logic                     busy
);

   state_t                    state_q, state_d;
   logic [LEN_BITS-1:0]       cnt_q, cnt_d;
   logic [DEPTH_BITS-1:0]     addr_q, addr_d;
   logic                      prefer_wr_q, prefer_wr_d;
   logic [WR_CAPTURE_DLY-1:0] wr_cap_q;
   logic [RD_LAT-1:0]         rd_pipe_q;
   logic [MEM_DATA_BITS-1:0]  rd_data_q;
   logic [MEM_DATA_BITS-1:0]  ram_rdata;
   logic                      rd_issue;
   logic                      wr_commit;
   logic                      unused_addr_hi;

   assign unused_addr_hi = ^{rd_burst_addr[ADDR_BITS-1:DEPTH_BITS],
                             wr_burst_addr[ADDR_BITS-1:DEPTH_BITS]};

   // A word requested in one cycle arrives on wr_burst_data the next.
   assign wr_commit = wr_cap_q[WR_CAPTURE_DLY-1];

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      addr_d            = addr_q;
      prefer_wr_d       = prefer_wr_q;
      wr_burst_data_req = 1'b0;
      wr_burst_finish   = 1'b0;
      rd_burst_finish   = 1'b0;
      rd_issue          = 1'b0;
      busy              = (state_q != S_IDLE);
      if (wr_commit) addr_d = addr_q + DEPTH_BITS'(1);
      unique case (state_q)
         S_IDLE: begin
            if (wr_burst_req && (prefer_wr_q || !rd_burst_req)) begin
               cnt_d       = wr_burst_len;
               addr_d      = wr_burst_addr[DEPTH_BITS-1:0];
               prefer_wr_d = 1'b0;
               state_d     = (wr_burst_len == '0) ? S_WR_FIN : S_WR_REQ;
            end else if (rd_burst_req) begin
               cnt_d       = rd_burst_len;
               addr_d      = rd_burst_addr[DEPTH_BITS-1:0];
               prefer_wr_d = 1'b1;
               state_d     = (rd_burst_len == '0) ? S_RD_FIN : S_RD_ISSUE;
            end
         end
         S_WR_REQ: begin
            wr_burst_data_req = 1'b1;
            cnt_d             = cnt_q - LEN_BITS'(1);
            if (cnt_q == LEN_BITS'(1)) state_d = S_WR_TAIL;
         end
         S_WR_TAIL: state_d = S_WR_FIN;
         S_WR_FIN: begin
            wr_burst_finish = 1'b1;
            state_d         = S_IDLE;
         end
         S_RD_ISSUE: begin
            rd_issue = 1'b1;
            addr_d   = addr_q + DEPTH_BITS'(1);
            cnt_d    = cnt_q - LEN_BITS'(1);
            if (cnt_q == LEN_BITS'(1)) state_d = S_RD_DRAIN;
         end
         // Finish only once every issued read has left the RAM stage.
         S_RD_DRAIN: if (rd_pipe_q[RD_LAT-2:0] == '0) state_d = S_RD_FIN;
         S_RD_FIN: begin
            rd_burst_finish = 1'b1;
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         prefer_wr_q <= 1'b1;
         wr_cap_q    <= '0;
         rd_pipe_q   <= '0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         prefer_wr_q <= prefer_wr_d;
         wr_cap_q    <= (wr_cap_q << 1) | WR_CAPTURE_DLY'(wr_burst_data_req);
         rd_pipe_q   <= (rd_pipe_q << 1) | RD_LAT'(rd_issue);
         rd_data_q   <= rd_pipe_q[RD_LAT-2] ? ram_rdata : '0;
      end
   end

   assign rd_burst_data_valid = rd_pipe_q[RD_LAT-1];
   assign rd_burst_data       = rd_data_q;

   burst_ram_sdp #(
      .DATA_BITS (MEM_DATA_BITS),
      .DEPTH_BITS(DEPTH_BITS)
   ) u_ram (
      .clk_i  (mem_clk),
      .we_i   (wr_commit),
      .waddr_i(addr_q),
      .wdata_i(wr_burst_data),
      .re_i   (rd_issue),
      .raddr_i(addr_q),
      .rdata_o(ram_rdata)
   );

endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Target-side (responder) end of the team's burst memory interface: serves rd/wr burst requests from an initiator such as the DDR3 traffic/test generator or the image-stitch frame writers.
- Backed by an on-chip simple-dual-port RAM rather than DDR3. Used as a drop-in DDR3 stand-in for simulation and for small on-chip frame buffers.
- Reproduces the controller-side handshake timing exactly: data_req, data_valid, finish.

Parameters:
- MEM_DATA_BITS, 64, width of one burst data word.
- ADDR_BITS, 24, width of the burst word address ports.
- DEPTH_BITS, 12, log2 of RAM depth in words. Only addr[DEPTH_BITS-1:0] is used; the upper bits are ignored.

Ports:
- mem_clk  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- rd_burst_req  input  1  read request; held by the initiator until finish.
- wr_burst_req  input  1  write request; held by the initiator until finish.
- rd_burst_len  input  10  read length in words.
- wr_burst_len  input  10  write length in words.
- rd_burst_addr  input  ADDR_BITS  read start word address.
- wr_burst_addr  input  ADDR_BITS  write start word address.
- rd_burst_data_valid  output  1  rd_burst_data is valid this cycle.
- rd_burst_data  output  MEM_DATA_BITS  read data.
- wr_burst_data_req  output  1  responder requests the next write word.
- wr_burst_data  input  MEM_DATA_BITS  write data; must be valid in the cycle after each data_req.
- rd_burst_finish  output  1  one-cycle pulse; read burst complete.
- wr_burst_finish  output  1  one-cycle pulse; write burst complete.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM to IDLE, arbitration pointer set to "write first". RAM contents are not cleared.
- FSM states: IDLE, WR_REQ, WR_TAIL, WR_FIN, RD_ISSUE, RD_DRAIN, RD_FIN.
- IDLE arbitration:
  - Only one request high: serve it.
  - Both high: round-robin. Serve the opposite type of the last burst served; after reset, write wins.
- Accept: on the accepting edge, latch len, addr[DEPTH_BITS-1:0] and type. Later changes on the request inputs are ignored until finish.
- Write burst, len=N>0, accept edge ends cycle 0:
  - wr_burst_data_req=1 in cycles 1..N (WR_REQ).
  - Word i (0-based) is sampled from wr_burst_data on the edge ending cycle i+2 and written to RAM[(addr+i) mod 2^DEPTH_BITS]. The last word's capture cycle N+1 is WR_TAIL.
  - wr_burst_finish=1 in cycle N+2 only (WR_FIN). The write is committed by then.
  - Back to IDLE; earliest next accept is the edge ending cycle N+3.
- Read burst, len=N>0:
  - RAM read addresses addr+i issued in cycles 1..N (RD_ISSUE).
  - 1-cycle synchronous RAM read plus an output register, so rd_burst_data_valid=1 with word i in cycle i+3, i.e. cycles 3..N+2.
  - rd_burst_finish=1 in cycle N+3 only.
  - Valid cycles are contiguous; there are no gaps.
- len=0: no data_req and no data_valid; the matching finish pulses in cycle 1.
- Address arithmetic: increment is modulo 2^DEPTH_BITS, so a burst wraps silently past the top of the RAM.
- Requests dropped mid-burst: the burst still runs to completion and finish still pulses (no abort).
- Read-after-write: a read accepted after wr_burst_finish returns the newly written data. No bypass is needed because of the commit-before-finish rule.
- Simultaneous rd/wr finish is impossible; only one burst is in flight at a time.
- rst asserted mid-burst: immediate return to IDLE with outputs 0. RAM words already written remain; no partial finish pulse is produced.

Decomposition:
- Package burst_if_pkg:
  - FSM state encoding localparams.
  - LEN_BITS=10.
  - Latency constants: WR_CAPTURE_DLY=1, RD_LAT=2.
- Sub-module burst_ram_sdp, parameters DATA_BITS and DEPTH_BITS:
  - One write port and one synchronous-read port.
  - No reset on the array; infers BRAM.
- The top level holds the FSM, arbiter, counters and read-valid delay pipe.

Test Plan:
- Write len=128 at addr 0 with word i = {8{i[7:0]}}, then read len=128 at addr 0:
  - data_req for exactly 128 cycles; wr finish in cycle 130.
  - 128 contiguous valid words matching the pattern, first in cycle 3; rd finish in cycle 131.
- rd_burst_req and wr_burst_req rise in the same cycle, with the requester re-requesting after every finish (pointer reset):
  - Order write, read, write, read.
  - busy deasserted for exactly one cycle between bursts.
- DEPTH_BITS=12, write len=8 at addr 0x000FFC, then read len=8 at addr 0:
  - Words 4..7 of the write land at RAM 0..3.
  - The read returns those words first.
- wr len=0, then rd len=0:
  - Each finish pulses in cycle 1.
  - No data_req or data_valid ever asserted.
- Initiator drops wr_burst_req in cycle 5 of a len=16 write:
  - data_req still spans 16 cycles.
  - wr_burst_finish still pulses in cycle 18.
- rst pulsed in cycle 10 of a len=64 read:
  - All outputs 0 in the following cycle and no finish pulse.
  - A subsequent read of the same region returns the previously written data unchanged.
